fft_shift_sync_ctrl: RTL

Consumes the 32-bit software shift-mask word that the OPB-to-fabric register drives in the user_clk domain. Applies the per-stage FFT shift schedule only on frame boundaries, so the shift never changes mid-frame. Counts overflow frames reported by the FFT. Packs a status word for a fabric-to-PPC readback register.

---
 rtl/fft_shift_sync_ctrl_if.sv | 39 +++
 rtl/fft_shift_sync_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fft_shift_sync_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_shift_sync_ctrl_if
//   Bundles the software shift-mask word, the frame/overflow inputs and all
//   status outputs of fft_shift_sync_ctrl.
//   master : drives shift_reg_in, sync_in, of_in; observes every output
//   slave  : the controller itself
// Ports carried:
//   shift_reg_in [31:0]   software word ([N_STAGES-1:0] mask, [31] clear)
//   sync_in, of_in        frame-start pulse, FFT overflow flag
//   shift_out, sync_out, ovf_count, of_last_frame, sync_err, pending,
//   status_out            controller outputs
// -----------------------------------------------------------------------------
interface fft_shift_sync_ctrl_if #(
   parameter int unsigned N_STAGES = 11,
   parameter int unsigned CNT_W    = 16
);
   logic [31:0]          shift_reg_in;
   logic                 sync_in;
   logic                 of_in;
   logic [N_STAGES-1:0]  shift_out;
   logic                 sync_out;
   logic [CNT_W-1:0]     ovf_count;
   logic                 of_last_frame;
   logic                 sync_err;
   logic                 pending;
   logic [31:0]          status_out;

   modport master (
      output shift_reg_in, sync_in, of_in,
      input  shift_out, sync_out, ovf_count, of_last_frame, sync_err,
             pending, status_out
   );

   modport slave (
      input  shift_reg_in, sync_in, of_in,
      output shift_out, sync_out, ovf_count, of_last_frame, sync_err,
             pending, status_out
   );
endinterface

// File: rtl/fft_shift_sync_ctrl.sv
// -----------------------------------------------------------------------------
// fft_shift_sync_ctrl
//   Applies the software FFT shift mask only on frame boundaries, counts
//   frames that overflowed and packs a status word for PPC readback.
// Ports:
//   user_clk    fabric clock, rising edge
//   user_rst_n  asynchronous active-low reset
//   bus         fft_shift_sync_ctrl_if.slave (mask word, sync, overflow in;
//               shift schedule, sync_out, counters, flags, status out)
// Optional build macro:
//   FFT_SHIFT_SYNC_CHECK_EN  when defined, a sync arriving off-period sets the
//                            sticky sync_err; otherwise sync_err is tied 0 and
//                            an early sync silently restarts the frame.
// -----------------------------------------------------------------------------
module fft_shift_sync_ctrl #(
   parameter int unsigned N_STAGES  = 11,
   parameter int unsigned FRAME_LEN = 2048,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 user_clk,
   input  logic                 user_rst_n,
   fft_shift_sync_ctrl_if.slave bus
);

   localparam int unsigned      FC_W     = $clog2(FRAME_LEN);
   localparam logic [FC_W-1:0]  LAST_CNT = FC_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state_q, state_d;
   logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
   logic                 acc_q, acc_d;
   logic [N_STAGES-1:0]  shift_q, shift_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 of_last_q, of_last_d;
   logic                 err_q, err_d;
   logic                 clr_prev_q;
   logic                 sync_q;
   logic                 pending_q;
   logic [31:0]          status_q;

   logic [N_STAGES-1:0]  mask;
   logic                 clr_rise;
   logic                 at_last;
   logic                 frame_ovf;
   logic [15:0]          cnt16;
   logic                 unused_bits;

   assign mask        = bus.shift_reg_in[N_STAGES-1:0];
   assign unused_bits = ^bus.shift_reg_in[30:N_STAGES];
   assign clr_rise    = bus.shift_reg_in[31] & ~clr_prev_q;
   assign at_last     = (frame_cnt_q == LAST_CNT);
   assign cnt16       = 16'(cnt_q);

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      acc_d       = acc_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      of_last_d   = of_last_q;
      err_d       = err_q;
      frame_ovf   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.sync_in) begin
               state_d     = RUN;
               frame_cnt_d = '0;
               shift_d     = mask;
            end
         end
         RUN: begin
            if (bus.sync_in || at_last) begin
               frame_ovf   = acc_q | bus.of_in;
               of_last_d   = frame_ovf;
               if (frame_ovf && (cnt_q != CNT_MAX))
                  cnt_d = cnt_q + CNT_W'(1);
               acc_d       = 1'b0;
               shift_d     = mask;
               frame_cnt_d = '0;
`ifdef FFT_SHIFT_SYNC_CHECK_EN
               if (bus.sync_in && !at_last)
                  err_d = 1'b1;
`endif
            end else begin
               frame_cnt_d = frame_cnt_q + FC_W'(1);
               acc_d       = acc_q | bus.of_in;
            end
         end
         default: state_d = IDLE;
      endcase

      // Clear wins over a boundary landing on the same cycle.
      if (clr_rise) begin
         cnt_d     = '0;
         of_last_d = 1'b0;
         err_d     = 1'b0;
      end
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state_q     <= IDLE;
         frame_cnt_q <= '0;
         acc_q       <= 1'b0;
         shift_q     <= '1;
         cnt_q       <= '0;
         of_last_q   <= 1'b0;
         err_q       <= 1'b0;
         clr_prev_q  <= 1'b0;
         sync_q      <= 1'b0;
         pending_q   <= 1'b0;
         status_q    <= '0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         acc_q       <= acc_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         of_last_q   <= of_last_d;
         err_q       <= err_d;
         clr_prev_q  <= bus.shift_reg_in[31];
         sync_q      <= bus.sync_in;
         // Compared against the value shift_out is about to take, so pending
         // is already low in the cycle the new mask appears.
         pending_q   <= (mask != shift_d);
         status_q    <= {err_q, of_last_q, pending_q, 13'b0, cnt16};
      end
   end

   assign bus.shift_out     = shift_q;
   assign bus.sync_out      = sync_q;
   assign bus.ovf_count     = cnt_q;
   assign bus.of_last_frame = of_last_q;
   assign bus.sync_err      = err_q;
   assign bus.pending       = pending_q;
   assign bus.status_out    = status_q;

endmodule
